// File: rtl/usb_pkg.sv
// Shared USB protocol encodings for the RX/TX packet engines and the protocol controller.
package usb_pkg;

  localparam int unsigned MAX_PACKET = 64;

  typedef enum logic [2:0] {
    RX_PKT_NONE = 3'b000,
    RX_PKT_OUT  = 3'b001,
    RX_PKT_IN   = 3'b010,
    RX_PKT_DATA = 3'b011,
    RX_PKT_ACK  = 3'b100,
    RX_PKT_NAK  = 3'b101,
    RX_PKT_RSVD = 3'b110,
    RX_PKT_ERR  = 3'b111
  } rx_pkt_e;

  typedef enum logic [1:0] {
    TX_PKT_NONE = 2'b00,
    TX_PKT_DATA = 2'b01,
    TX_PKT_ACK  = 2'b10,
    TX_PKT_NAK  = 2'b11
  } tx_pkt_e;

endpackage

// File: rtl/protocol_controller.sv
// USB full-speed bulk transaction sequencer: steers OUT/IN transactions, picks the
// handshake to send, reports status flags and flushes the shared buffer on errors.
//
// state         | meaning
// ST_IDLE       | waiting for an OUT or IN token
// ST_RX_WAIT    | OUT accepted, waiting for the DATA packet
// ST_SEND_ACK   | requesting ACK from TX until it starts sending
// ST_SEND_NAK   | requesting NAK from TX until it starts sending
// ST_TX_DATA    | requesting DATA from TX until it starts sending
// ST_TX_BUSY    | TX is sending; wait for it to go idle
// ST_TX_WAIT_HS | DATA sent, waiting for the host handshake
module protocol_controller
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PACKET = usb_pkg::MAX_PACKET
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       buffer_reserved,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_status,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       d_mode,
  output logic [1:0] tx_packet,
  output logic       clear
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_WAIT, ST_SEND_ACK, ST_SEND_NAK, ST_TX_DATA, ST_TX_BUSY, ST_TX_WAIT_HS
  } state_e;

  localparam logic [6:0] LP_MAX_OCC = 7'(MAX_PACKET);

  state_e  r_state, w_state_nxt;
  tx_pkt_e r_tx_packet, w_tx_packet_nxt;
  tx_pkt_e r_last_tx, w_last_tx_nxt;
  logic    r_d_mode, w_d_mode_nxt;
  logic    r_clear, w_clear_nxt;
  logic    r_rx_ready, w_rx_ready_nxt;
  logic    r_rx_active, w_rx_active_nxt;
  logic    r_rx_error, w_rx_error_nxt;
  logic    r_tx_active, w_tx_active_nxt;
  logic    r_tx_error, w_tx_error_nxt;
  rx_pkt_e w_rx;
  logic    w_can_send;

  assign w_rx       = rx_pkt_e'(rx_packet);
  assign w_can_send = !buffer_reserved && (buffer_occupancy != 7'd0) &&
                      (buffer_occupancy <= LP_MAX_OCC);

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_packet_nxt = r_tx_packet;
    w_last_tx_nxt   = r_last_tx;
    w_d_mode_nxt    = r_d_mode;
    w_clear_nxt     = 1'b0;
    w_rx_ready_nxt  = r_rx_ready && (buffer_occupancy != 7'd0);
    w_rx_active_nxt = r_rx_active;
    w_rx_error_nxt  = r_rx_error;
    w_tx_active_nxt = r_tx_active;
    w_tx_error_nxt  = r_tx_error;
    case (r_state)
      ST_IDLE: begin
        case (w_rx)
          RX_PKT_OUT: begin
            w_rx_ready_nxt = 1'b0;
            if (!buffer_reserved) begin
              w_state_nxt     = ST_RX_WAIT;
              w_rx_active_nxt = 1'b1;
              w_rx_error_nxt  = 1'b0;
              w_clear_nxt     = 1'b1;
            end else begin
              w_state_nxt     = ST_SEND_NAK;
              w_tx_packet_nxt = TX_PKT_NAK;
              w_d_mode_nxt    = 1'b1;
            end
          end
          RX_PKT_IN: begin
            w_d_mode_nxt = 1'b1;
            if (w_can_send) begin
              w_state_nxt     = ST_TX_DATA;
              w_tx_packet_nxt = TX_PKT_DATA;
              w_tx_active_nxt = 1'b1;
              w_tx_error_nxt  = 1'b0;
            end else begin
              w_state_nxt     = ST_SEND_NAK;
              w_tx_packet_nxt = TX_PKT_NAK;
            end
          end
          default: ;
        endcase
      end
      ST_RX_WAIT: begin
        case (w_rx)
          RX_PKT_DATA: begin
            w_state_nxt     = ST_SEND_ACK;
            w_tx_packet_nxt = TX_PKT_ACK;
            w_d_mode_nxt    = 1'b1;
          end
          RX_PKT_ERR, RX_PKT_OUT, RX_PKT_IN: begin
            w_state_nxt     = ST_IDLE;
            w_rx_error_nxt  = 1'b1;
            w_rx_active_nxt = 1'b0;
            w_clear_nxt     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_SEND_ACK, ST_SEND_NAK, ST_TX_DATA: begin
        // Remember what went out so TX_BUSY knows where to return.
        if (tx_status) begin
          w_state_nxt     = ST_TX_BUSY;
          w_last_tx_nxt   = r_tx_packet;
          w_tx_packet_nxt = TX_PKT_NONE;
        end
      end
      ST_TX_BUSY: begin
        if (!tx_status) begin
          w_d_mode_nxt = 1'b0;
          if (r_last_tx == TX_PKT_DATA) begin
            w_state_nxt = ST_TX_WAIT_HS;
          end else begin
            w_state_nxt = ST_IDLE;
            if (r_last_tx == TX_PKT_ACK) begin
              w_rx_ready_nxt  = 1'b1;
              w_rx_active_nxt = 1'b0;
            end
          end
        end
      end
      ST_TX_WAIT_HS: begin
        case (w_rx)
          RX_PKT_NONE, RX_PKT_RSVD: ;
          RX_PKT_ACK: begin
            w_state_nxt     = ST_IDLE;
            w_tx_active_nxt = 1'b0;
            w_clear_nxt     = 1'b1;
          end
          default: begin
            w_state_nxt     = ST_IDLE;
            w_tx_active_nxt = 1'b0;
            w_tx_error_nxt  = 1'b1;
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state     <= ST_IDLE;
      r_tx_packet <= TX_PKT_NONE;
      r_last_tx   <= TX_PKT_NONE;
      r_d_mode    <= 1'b0;
      r_clear     <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_rx_active <= 1'b0;
      r_rx_error  <= 1'b0;
      r_tx_active <= 1'b0;
      r_tx_error  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_packet <= w_tx_packet_nxt;
      r_last_tx   <= w_last_tx_nxt;
      r_d_mode    <= w_d_mode_nxt;
      r_clear     <= w_clear_nxt;
      r_rx_ready  <= w_rx_ready_nxt;
      r_rx_active <= w_rx_active_nxt;
      r_rx_error  <= w_rx_error_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_tx_error  <= w_tx_error_nxt;
    end
  end

  assign tx_packet          = r_tx_packet;
  assign d_mode             = r_d_mode;
  assign clear              = r_clear;
  assign rx_data_ready      = r_rx_ready;
  assign rx_transfer_active = r_rx_active;
  assign rx_error           = r_rx_error;
  assign tx_transfer_active = r_tx_active;
  assign tx_error           = r_tx_error;

endmodule

// File: tb/tb_protocol_controller.sv
// Scoreboard bench for protocol_controller: each step pushes the expected output word
// {tx_packet, d_mode, clear, rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error}.
module tb_protocol_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] rx_packet;
  logic       buffer_reserved;
  logic [6:0] buffer_occupancy;
  logic       tx_status;
  logic       rx_data_ready, rx_transfer_active, rx_error;
  logic       tx_transfer_active, tx_error, d_mode, clear;
  logic [1:0] tx_packet;

  logic [8:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  protocol_controller dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .buffer_reserved(buffer_reserved),
    .buffer_occupancy(buffer_occupancy), .tx_status(tx_status),
    .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
    .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
    .d_mode(d_mode), .tx_packet(tx_packet), .clear(clear)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NONE = 3'b000, OUT = 3'b001, IN = 3'b010, DATA = 3'b011;
  localparam logic [2:0] ACK = 3'b100, NAK = 3'b101, ERR = 3'b111;

  function automatic logic [8:0] obs();
    return {tx_packet, d_mode, clear, rx_data_ready, rx_transfer_active, rx_error,
            tx_transfer_active, tx_error};
  endfunction

  // Stimulus entry: {rx_packet, buffer_reserved, buffer_occupancy, tx_status, expected}.
  function automatic logic [20:0] e(input logic [2:0] rx, input logic res,
                                    input logic [6:0] occ, input logic txs, input logic [8:0] ex);
    return {rx, res, occ, txs, ex};
  endfunction

  task automatic test_reset();
    logic [20:0] t[$];
    logic [8:0]  ex;
    n_rst = 1'b1;
    t = '{e(ERR, 1, 7'd64, 1, 9'b00_00_000_00), e(ERR, 1, 7'd64, 1, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL reset_held step %0d: got %b expected %b", i, obs(), ex);
      end
    end
    n_rst = 1'b0;
    t = '{e(NONE, 0, 0, 0, 9'b00_00_000_00), e(NONE, 0, 0, 0, 9'b00_00_000_00),
          e(NONE, 0, 0, 0, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL reset_release step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_out_ack();
    logic [20:0] t[$];
    logic [8:0]  ex;
    t = '{e(OUT,  0, 8, 0, 9'b00_01_010_00), e(NONE, 0, 8, 0, 9'b00_00_010_00),
          e(DATA, 0, 8, 0, 9'b10_10_010_00), e(NONE, 0, 8, 0, 9'b10_10_010_00),
          e(NONE, 0, 8, 1, 9'b00_10_010_00), e(NONE, 0, 8, 1, 9'b00_10_010_00),
          e(NONE, 0, 8, 1, 9'b00_10_010_00), e(NONE, 0, 8, 1, 9'b00_10_010_00),
          e(NONE, 0, 8, 1, 9'b00_10_010_00), e(NONE, 0, 8, 0, 9'b00_00_100_00),
          e(NONE, 0, 8, 0, 9'b00_00_100_00), e(NONE, 0, 0, 0, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL out_ack step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_in_ack();
    logic [20:0] t[$];
    logic [8:0]  ex;
    // ACK while DATA is still pending must be ignored.
    t = '{e(IN,   0, 16, 0, 9'b01_10_000_10), e(ACK,  0, 16, 0, 9'b01_10_000_10),
          e(NONE, 0, 16, 1, 9'b00_10_000_10), e(NONE, 0, 16, 1, 9'b00_10_000_10),
          e(NONE, 0, 16, 0, 9'b00_00_000_10), e(NONE, 0, 16, 0, 9'b00_00_000_10),
          e(ACK,  0, 16, 0, 9'b00_01_000_00), e(NONE, 0, 0,  0, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL in_ack step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_nak_responses();
    logic [20:0] t[$];
    logic [8:0]  ex;
    t = '{e(IN,   0, 0,  0, 9'b11_10_000_00), e(NONE, 0, 0,  1, 9'b00_10_000_00),
          e(NONE, 0, 0,  0, 9'b00_00_000_00), e(IN,   1, 16, 0, 9'b11_10_000_00),
          e(NONE, 1, 16, 1, 9'b00_10_000_00), e(NONE, 1, 16, 0, 9'b00_00_000_00),
          e(OUT,  1, 16, 0, 9'b11_10_000_00), e(NONE, 1, 16, 1, 9'b00_10_000_00),
          e(NONE, 1, 16, 0, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL nak_response step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_host_nak_retry();
    logic [20:0] t[$];
    logic [8:0]  ex;
    t = '{e(IN,   0, 16, 0, 9'b01_10_000_10), e(NONE, 0, 16, 1, 9'b00_10_000_10),
          e(NONE, 0, 16, 0, 9'b00_00_000_10), e(NAK,  0, 16, 0, 9'b00_00_000_01),
          e(NONE, 0, 16, 0, 9'b00_00_000_01), e(IN,   0, 16, 0, 9'b01_10_000_10),
          e(NONE, 0, 16, 1, 9'b00_10_000_10), e(NONE, 0, 16, 0, 9'b00_00_000_10),
          e(ACK,  0, 16, 0, 9'b00_01_000_00), e(NONE, 0, 0,  0, 9'b00_00_000_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL host_nak_retry step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_rx_error();
    logic [20:0] t[$];
    logic [8:0]  ex;
    t = '{e(OUT,  0, 0, 0, 9'b00_01_010_00), e(ERR,  0, 0, 0, 9'b00_01_001_00),
          e(NONE, 0, 0, 0, 9'b00_00_001_00), e(OUT,  0, 0, 0, 9'b00_01_010_00),
          e(IN,   0, 0, 0, 9'b00_01_001_00), e(NONE, 0, 0, 0, 9'b00_00_001_00)};
    foreach (t[i]) begin
      {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = t[i][20:9];
      sb_q.push_back(t[i][8:0]);
      @(negedge clk);
      ex = sb_q.pop_front();
      n_checks++;
      if (obs() !== ex) begin
        n_fail++;
        $display("FAIL rx_error step %0d: got %b expected %b", i, obs(), ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] ex;
    {rx_packet, buffer_reserved, buffer_occupancy, tx_status} = {IN, 1'b0, 7'd16, 1'b0};
    sb_q.push_back(9'b01_10_001_10);
    @(negedge clk);
    ex = sb_q.pop_front();
    n_checks++;
    if (obs() !== ex) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %b expected %b", obs(), ex);
    end
    rx_packet = NONE;
    n_rst = 1'b1;
    sb_q.push_back(9'b00_00_000_00);
    #1;
    ex = sb_q.pop_front();
    n_checks++;
    if (obs() !== ex) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", obs(), ex);
    end
    @(negedge clk);
    n_rst = 1'b0;
    sb_q.push_back(9'b00_00_000_00);
    @(negedge clk);
    ex = sb_q.pop_front();
    n_checks++;
    if (obs() !== ex) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %b expected %b", obs(), ex);
    end
  endtask

  initial begin
    n_rst = 1'b1;
    rx_packet = 3'b000;
    buffer_reserved = 1'b0;
    buffer_occupancy = 7'd0;
    tx_status = 1'b0;
    @(negedge clk);
    test_reset();
    test_out_ack();
    test_in_ack();
    test_nak_responses();
    test_host_nak_retry();
    test_rx_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
